col_ce_nco: RTL and testbench

//   Parametrised multi-channel numerically-controlled clock-enable generator in the clk_in domain
//   (normally the color x16 clock from the clock DCM stage). Each channel is a phase

---
 rtl/col_ce_nco_if.sv | 23 ++
 rtl/col_ce_nco.sv | 82 ++++++++
 tb/tb_col_ce_nco.sv | 138 +++++++++++++
 3 files changed

// File: rtl/col_ce_nco_if.sv
// Bus bundle for the multi-channel clock-enable NCO: standard request and enable in,
// per-channel enables, phase clocks and lock status out.
interface col_ce_nco_if #(
    parameter int CHANNELS = 2
);
    logic                enable;
    logic                mode_sel;
    logic [CHANNELS-1:0] ce;
    logic [CHANNELS-1:0] phase_clk;
    logic                mode_active;
    logic                mode_busy;
    logic                ready;

    modport master (
        output enable, mode_sel,
        input  ce, phase_clk, mode_active, mode_busy, ready
    );

    modport slave (
        input  enable, mode_sel,
        output ce, phase_clk, mode_active, mode_busy, ready
    );
endinterface

// File: rtl/col_ce_nco.sv
// Multi-channel phase-accumulator clock-enable generator with NTSC/PAL increment tables.
// Standard switches land on a channel-0 wrap, realign every channel and restart the lock count.
module col_ce_nco #(
    parameter int                          CHANNELS   = 2,
    parameter int                          ACC_W      = 24,
    parameter logic [CHANNELS*ACC_W-1:0]   INC_NTSC   = '0,
    parameter logic [CHANNELS*ACC_W-1:0]   INC_PAL    = '0,
    parameter int                          LOCK_WRAPS = 16
) (
    input  logic        clk_in,
    input  logic        reset,
    col_ce_nco_if.slave bus
);

    localparam logic [15:0] LOCK_MAX = 16'(LOCK_WRAPS);

    logic [CHANNELS-1:0] carry;
    logic                mode_active;
    logic                mode_busy;
    logic                inc0_zero;
    logic                apply;
    logic [15:0]         lock_cnt;

    assign mode_busy = (bus.mode_sel != mode_active);
    // A zero channel-0 increment never wraps, so the switch would otherwise stall forever.
    assign apply     = bus.enable && mode_busy && (carry[0] || inc0_zero);

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
        localparam logic [ACC_W-1:0] INC_N = INC_NTSC[ch*ACC_W +: ACC_W];
        localparam logic [ACC_W-1:0] INC_P = INC_PAL[ch*ACC_W +: ACC_W];

        logic [ACC_W-1:0] acc;
        logic [ACC_W-1:0] inc;
        logic [ACC_W:0]   sum;
        logic             ce_q;

        assign sum       = {1'b0, acc} + {1'b0, inc};
        assign carry[ch] = sum[ACC_W];

        always_ff @(posedge clk_in or posedge reset) begin
            if (reset) begin
                acc  <= '0;
                inc  <= INC_N;
                ce_q <= 1'b0;
            end else if (bus.enable) begin
                ce_q <= sum[ACC_W];
                if (apply) begin
                    acc <= '0;
                    inc <= bus.mode_sel ? INC_P : INC_N;
                end else begin
                    acc <= sum[ACC_W-1:0];
                end
            end else begin
                ce_q <= 1'b0;
            end
        end

        assign bus.ce[ch]        = ce_q;
        assign bus.phase_clk[ch] = acc[ACC_W-1];
    end

    assign inc0_zero = (g_chan[0].inc == '0);

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            mode_active <= 1'b0;
            lock_cnt    <= '0;
        end else if (bus.enable) begin
            if (apply) begin
                mode_active <= bus.mode_sel;
                lock_cnt    <= '0;
            end else if (carry[0] && (lock_cnt != LOCK_MAX)) begin
                lock_cnt <= lock_cnt + 16'd1;
            end
        end
    end

    assign bus.mode_active = mode_active;
    assign bus.mode_busy   = mode_busy;
    assign bus.ready       = (lock_cnt == LOCK_MAX) && !mode_busy;

endmodule

// File: tb/tb_col_ce_nco.sv
// Directed bench for col_ce_nco: 2 channels, 8-bit accumulators, NTSC {96,64}, PAL {128,32}, lock after 4 wraps.
// Observed vector layout: {ready, mode_busy, mode_active, phase_clk[1:0], ce[1:0]}.
module tb_col_ce_nco;

    logic clk_in = 1'b0;
    logic reset  = 1'b1;
    int   n_cmp  = 0;
    int   n_err  = 0;

    col_ce_nco_if #(.CHANNELS(2)) bus ();

    col_ce_nco #(
        .CHANNELS   (2),
        .ACC_W      (8),
        .INC_NTSC   (16'h6040),
        .INC_PAL    (16'h8020),
        .LOCK_WRAPS (4)
    ) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [6:0] got, input logic [6:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%b want=%b", tag, got, want);
        end
    endtask

    function automatic logic [6:0] obs();
        return {bus.ready, bus.mode_busy, bus.mode_active, bus.phase_clk, bus.ce};
    endfunction

    // NTSC cadence k edges after realign: ch0 +64, ch1 +96 (hand-tabulated over the 8-cycle period).
    function automatic logic [6:0] ntsc_vec(input int k, input logic rdy, input logic busy);
        logic [1:0] ph;
        logic [1:0] c;
        case (k % 8)
            1: begin ph = 2'b00; c = 2'b00; end
            2: begin ph = 2'b11; c = 2'b00; end
            3: begin ph = 2'b01; c = 2'b10; end
            4: begin ph = 2'b10; c = 2'b01; end
            5: begin ph = 2'b10; c = 2'b00; end
            6: begin ph = 2'b01; c = 2'b10; end
            7: begin ph = 2'b11; c = 2'b00; end
            default: begin ph = 2'b00; c = 2'b11; end
        endcase
        return {rdy, busy, 1'b0, ph, c};
    endfunction

    // PAL cadence j edges after realign: ch0 +32 wraps every 8, ch1 +128 wraps every 2.
    function automatic logic [6:0] pal_vec(input int j, input logic rdy, input logic busy);
        logic [1:0] ph;
        logic [1:0] c;
        ph = {(j % 2) == 1, (j % 8) >= 4};
        c  = {(j % 2) == 0, (j % 8) == 0};
        return {rdy, busy, 1'b1, ph, c};
    endfunction

    task automatic step_chk(input string tag, input logic [6:0] want);
        @(posedge clk_in);
        #2;
        check_eq(tag, obs(), want);
    endtask

    initial begin
        bus.enable   = 1'b1;
        bus.mode_sel = 1'b0;

        // Reset state, including combinational busy tracking mode_sel.
        @(posedge clk_in); #2;
        check_eq("rst_idle", obs(), 7'b0000000);
        bus.mode_sel = 1'b1; #1;
        check_eq("rst_busy", obs(), 7'b0100000);
        bus.mode_sel = 1'b0;
        @(posedge clk_in); #2;
        check_eq("rst_hold", obs(), 7'b0000000);
        reset = 1'b0;

        // NTSC cadence from reset, ready on the 4th ch0 wrap.
        for (int k = 1; k <= 16; k++)
            step_chk($sformatf("ntsc k=%0d", k), ntsc_vec(k, k == 16, 1'b0));
        step_chk("ntsc k=17", ntsc_vec(17, 1'b1, 1'b0));

        // Switch to PAL mid-period.
        bus.mode_sel = 1'b1; #1;
        check_eq("sw_req", obs(), ntsc_vec(17, 1'b0, 1'b1));
        step_chk("sw_k18", ntsc_vec(18, 1'b0, 1'b1));
        step_chk("sw_k19", ntsc_vec(19, 1'b0, 1'b1));
        step_chk("sw_apply", 7'b0010001);
        for (int j = 1; j <= 34; j++)
            step_chk($sformatf("pal j=%0d", j), pal_vec(j, j >= 32, 1'b0));

        // Short request back to NTSC that withdraws before any ch0 wrap.
        bus.mode_sel = 1'b0; #1;
        check_eq("glitch_req", obs(), pal_vec(34, 1'b0, 1'b1));
        step_chk("glitch j=35", pal_vec(35, 1'b0, 1'b1));
        step_chk("glitch j=36", pal_vec(36, 1'b0, 1'b1));
        bus.mode_sel = 1'b1; #1;
        check_eq("glitch_end", obs(), pal_vec(36, 1'b1, 1'b0));
        for (int j = 37; j <= 46; j++)
            step_chk($sformatf("pal j=%0d", j), pal_vec(j, 1'b1, 1'b0));

        // Enable low with a pending switch: everything frozen, ce forced low.
        bus.enable   = 1'b0;
        bus.mode_sel = 1'b0; #1;
        check_eq("hold_req", obs(), pal_vec(46, 1'b0, 1'b1));
        for (int h = 1; h <= 5; h++)
            step_chk($sformatf("hold h=%0d", h), 7'b0110100);
        bus.enable = 1'b1;
        step_chk("resume j=47", pal_vec(47, 1'b0, 1'b1));
        step_chk("resume_apply", 7'b0000011);
        for (int k = 1; k <= 17; k++)
            step_chk($sformatf("ntsc2 k=%0d", k), ntsc_vec(k, k >= 16, 1'b0));

        // Asynchronous reset in the middle of a pending switch.
        bus.mode_sel = 1'b1;
        step_chk("pre_rst k=18", ntsc_vec(18, 1'b0, 1'b1));
        step_chk("pre_rst k=19", ntsc_vec(19, 1'b0, 1'b1));
        #1 reset = 1'b1;
        #1 check_eq("async_rst", obs(), 7'b0100000);
        step_chk("rst_held1", 7'b0100000);
        step_chk("rst_held2", 7'b0100000);
        reset = 1'b0;
        for (int k = 1; k <= 3; k++)
            step_chk($sformatf("post_rst k=%0d", k), ntsc_vec(k, 1'b0, 1'b1));
        step_chk("post_rst_apply", 7'b0010001);
        step_chk("post_rst j=1", pal_vec(1, 1'b0, 1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
